// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit.
// pc_action_e is the one action chosen per cycle by the priority encoder;
// pc_next_addr gives the sequential successor of a PC value.
// Helpers work on a 64-bit carrier, so the PC width must be 64 bits or less.
// Callers truncate the result back to their own width, which gives the
// modulo-2^WIDTH wrap.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD = 3'd0,
    PC_INC  = 3'd1,
    PC_LOAD = 3'd2,
    PC_JREL = 3'd3,
    PC_CALL = 3'd4,
    PC_RET  = 3'd5
  } pc_action_e;

  localparam int PC_MAX_WIDTH = 64;

  // Successor address. The caller truncates the result to its width, and
  // that truncation is what makes all-ones wrap to zero.
  function automatic logic [PC_MAX_WIDTH-1:0] pc_next_addr(
    input logic [PC_MAX_WIDTH-1:0] pc
  );
    return pc + 64'd1;
  endfunction

  // Fixed-priority action select. Reset is handled by the registers
  // themselves, so stall is the highest priority here.
  function automatic pc_action_e pc_decode(
    input logic stall,
    input logic load,
    input logic jrel,
    input logic call,
    input logic ret,
    input logic inc
  );
    pc_action_e act;
    act = PC_HOLD;
    if (stall)     act = PC_HOLD;
    else if (load) act = PC_LOAD;
    else if (jrel) act = PC_JREL;
    else if (call) act = PC_CALL;
    else if (ret)  act = PC_RET;
    else if (inc)  act = PC_INC;
    return act;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO: DEPTH entries of WIDTH bits.
// The owner never asserts push and pop in the same cycle. It also never
// pushes while full or pops while empty.
// Entry contents are not reset; only the occupancy count is.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty
);

  localparam int DW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DW-1:0]    cnt;
  logic [DW-1:0]    top_idx;

  // Occupancy count: cleared on reset, moved by one per push or pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (push) begin
      cnt <= cnt + DW'(1);
    end else if (pop) begin
      cnt <= cnt - DW'(1);
    end
  end

  // Entry storage: a push writes the slot just above the current top.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[cnt] <= push_data;
    end
  end

  // Top-of-stack view and status flags, derived from the count.
  always_comb begin
    top_idx = cnt - DW'(1);
    top     = '0;
    if (cnt != '0) begin
      top = mem[top_idx];
    end
    depth = cnt;
    full  = (cnt == DW'(DEPTH));
    empty = (cnt == '0);
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with an integrated return-address stack.
// Per-cycle priority: reset > stall > load > [jrel] > call > ret > inc > hold.
// Optional feature macro: PCU_REL_BRANCH_EN. When it is defined, the jrel port
// is added and gives PC <= PC + in, where in is a two's-complement offset.
// ovf and unf are sticky error flags; only reset clears them.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       inc,
  input  logic                       load,
  input  logic                       call,
  input  logic                       ret,
  input  logic [WIDTH-1:0]           in,
`ifdef PCU_REL_BRANCH_EN
  input  logic                       jrel,
`endif
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       unf
);

  logic             jrel_req;
  pc_action_e       action;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_rel;
  logic [WIDTH-1:0] stk_top;
  logic             stk_full;
  logic             stk_empty;
  logic             push;
  logic             pop;
  logic             ovf_q;
  logic             unf_q;

`ifdef PCU_REL_BRANCH_EN
  assign jrel_req = jrel;
`else
  assign jrel_req = 1'b0;
`endif

  // Action select, candidate addresses, and the stack handshake.
  always_comb begin
    action = pc_decode(stall, load, jrel_req, call, ret, inc);
    pc_inc = WIDTH'(pc_next_addr(PC_MAX_WIDTH'(pc)));
    pc_rel = pc + in;
    push   = 1'b0;
    pop    = 1'b0;
    if (!reset) begin
      push = (action == PC_CALL) && !stk_full;
      pop  = (action == PC_RET)  && !stk_empty;
    end
  end

  // Registered PC mux and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      unique case (action)
        PC_INC:  pc <= pc_inc;
        PC_LOAD: pc <= in;
        PC_JREL: pc <= pc_rel;
        PC_CALL: begin
          pc <= in;
          if (stk_full) begin
            ovf_q <= 1'b1;
          end
        end
        PC_RET: begin
          if (stk_empty) begin
            pc    <= pc_inc;
            unf_q <= 1'b1;
          end else begin
            pc <= stk_top;
          end
        end
        default: pc <= pc;
      endcase
    end
  end

  pc_ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .depth     (depth),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  assign out   = pc;
  assign full  = stk_full;
  assign empty = stk_empty;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit (WIDTH=16, DEPTH=8, RESET_VEC=0).
// Directed table, hand-written stack sequences, then random traffic checked
// against a queue-based reference model.
module tb_pc_unit;

  localparam int W = 16;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0, stall = 1'b0, inc = 1'b0, load = 1'b0;
  logic         call = 1'b0, ret = 1'b0, jrel = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] out;
  logic [3:0]   depth;
  logic         full, empty, ovf, unf;

  int checks = 0;
  int failures = 0;
  int step = 0;

  // Reference model state.
  logic [W-1:0] m_pc;
  logic [W-1:0] m_stack[$];
  logic         m_ovf, m_unf;

  pc_unit #(.WIDTH(W), .DEPTH(D), .RESET_VEC(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .inc   (inc),
    .load  (load),
    .call  (call),
    .ret   (ret),
    .in    (din),
`ifdef PCU_REL_BRANCH_EN
    .jrel  (jrel),
`endif
    .out   (out),
    .depth (depth),
    .full  (full),
    .empty (empty),
    .ovf   (ovf),
    .unf   (unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         r, s, i, l, c, rt;
    logic [W-1:0] d;
    logic [W-1:0] eo;
    int           ed;
    logic         eovf, eunf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, s, i, l, c, rt, input logic [W-1:0] d,
                              input logic [W-1:0] eo, input int ed, input logic eovf, eunf);
    vec_t v;
    v.r = r; v.s = s; v.i = i; v.l = l; v.c = c; v.rt = rt; v.d = d;
    v.eo = eo; v.ed = ed; v.eovf = eovf; v.eunf = eunf;
    return v;
  endfunction

  // Behaviour as a plain priority list over a queue-based stack.
  task automatic model_step();
    logic jr;
    jr = 1'b0;
`ifdef PCU_REL_BRANCH_EN
    jr = jrel;
`endif
    if (reset) begin
      m_pc = 16'h0000; m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (stall) begin
      // everything holds
    end else if (load) begin
      m_pc = din;
    end else if (jr) begin
      m_pc = W'(int'(m_pc) + int'(din));
    end else if (call) begin
      if (m_stack.size() < D) m_stack.push_back(W'(int'(m_pc) + 1));
      else m_ovf = 1'b1;
      m_pc = din;
    end else if (ret) begin
      if (m_stack.size() == 0) begin
        m_pc = W'(int'(m_pc) + 1); m_unf = 1'b1;
      end else begin
        m_pc = m_stack.pop_back();
      end
    end else if (inc) begin
      m_pc = W'(int'(m_pc) + 1);
    end
  endtask

  task automatic apply(input logic r, s, i, l, c, rt, j, input logic [W-1:0] d);
    reset = r; stall = s; inc = i; load = l; call = c; ret = rt; jrel = j; din = d;
    @(posedge clk);
    #1;
    model_step();
    step++;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h want=%0h", nm, step, act, exp);
    end
  endtask

  task automatic check_all(input logic [W-1:0] eo, input int ed, input logic eovf, input logic eunf);
    check("out",   32'(out),   32'(eo));
    check("depth", 32'(depth), 32'(ed));
    check("full",  32'(full),  32'(ed == D));
    check("empty", 32'(empty), 32'(ed == 0));
    check("ovf",   32'(ovf),   32'(eovf));
    check("unf",   32'(unf),   32'(eunf));
  endtask

  initial begin
    // Directed table: reset, inc, call/ret, underflow, priority, stall, wrap.
    //               r  s  i  l  c  rt  in        out      dep ovf unf
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0001, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0002, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0003, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0010, 16'h0010, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0100, 16'h0100, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0101, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0011, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0005, 16'h0005, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0006, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0007, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0020, 16'h0020, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 16'h0ABC, 16'h0ABC, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0300, 16'h0300, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 16'h0400, 16'h0300, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 0, 1, 16'h0500, 16'h0300, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 16'h0600, 16'h0600, 2, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0301, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 16'hFFFF, 16'hFFFF, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0ABD, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 16'h0700, 16'h0000, 0, 0, 0));

    foreach (tbl[k]) begin
      apply(tbl[k].r, tbl[k].s, tbl[k].i, tbl[k].l, tbl[k].c, tbl[k].rt, 1'b0, tbl[k].d);
      check_all(tbl[k].eo, tbl[k].ed, tbl[k].eovf, tbl[k].eunf);
    end

    // Fill the stack, overflow once, then unwind in LIFO order.
    apply(1, 0, 0, 0, 0, 0, 0, 16'h0000);
    apply(0, 0, 0, 1, 0, 0, 0, 16'h1000);
    check_all(16'h1000, 0, 0, 0);
    for (int i = 0; i < D; i++) begin
      apply(0, 0, 0, 0, 1, 0, 0, W'(16'h2000 + i * 16'h10));
      check_all(W'(16'h2000 + i * 16'h10), i + 1, 0, 0);
    end
    apply(0, 0, 0, 0, 1, 0, 0, 16'h0200);
    check_all(16'h0200, D, 1, 0);
    for (int k = 0; k < D; k++) begin
      int j;
      logic [W-1:0] e;
      j = D - 1 - k;
      e = (j == 0) ? 16'h1001 : W'(16'h2001 + (j - 1) * 16'h10);
      apply(0, 0, 0, 0, 0, 1, 0, 16'h0000);
      check_all(e, j, 1, 0);
    end
    apply(0, 0, 0, 0, 0, 1, 0, 16'h0000);
    check_all(16'h1002, 0, 1, 1);

    // Reset while a push and while a pop are requested: stack ends empty.
    apply(0, 0, 0, 0, 1, 0, 0, 16'h0040);
    apply(1, 0, 0, 0, 1, 0, 0, 16'h0050);
    check_all(16'h0000, 0, 0, 0);
    apply(0, 0, 0, 0, 1, 0, 0, 16'h0060);
    apply(1, 0, 0, 0, 0, 1, 0, 16'h0000);
    check_all(16'h0000, 0, 0, 0);

`ifdef PCU_REL_BRANCH_EN
    // Relative branch: negative offset, loses to load, beats call.
    apply(0, 0, 0, 1, 0, 0, 0, 16'h0100);
    apply(0, 0, 0, 0, 0, 0, 1, 16'hFFF0);
    check_all(16'h00F0, 0, 0, 0);
    apply(0, 0, 0, 1, 0, 0, 1, 16'h0333);
    check_all(16'h0333, 0, 0, 0);
    apply(0, 0, 0, 0, 1, 0, 1, 16'h0010);
    check_all(16'h0343, 0, 0, 0);
`endif

    // Random traffic against the reference model.
    apply(1, 0, 0, 0, 0, 0, 0, 16'h0000);
    for (int n = 0; n < 600; n++) begin
      logic r, s, i, l, c, rt, j;
      logic [W-1:0] d;
      r  = ($urandom_range(63) == 0);
      s  = ($urandom_range(7) == 0);
      i  = $urandom_range(1);
      l  = ($urandom_range(5) == 0);
      c  = ($urandom_range(2) == 0);
      rt = ($urandom_range(2) == 0);
      j  = 1'b0;
`ifdef PCU_REL_BRANCH_EN
      j  = ($urandom_range(5) == 0);
`endif
      d  = W'($urandom);
      if (n % 5 == 0) d = 16'hFFFF;
      apply(r, s, i, l, c, rt, j, d);
      check_all(m_pc, m_stack.size(), m_ovf, m_unf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
